// File: rtl/inta_master.sv
// 8259A-style interrupt-acknowledge master: qualifies INT, issues two INTA_n pulses, captures the vector.
// Optional LOCK_n output is built only when INTA_LOCK_EN is defined.
module inta_master #(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INT,
    input  logic       IF_EN,
    input  logic [7:0] D,
    input  logic       vec_ack,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vec_valid,
`ifdef INTA_LOCK_EN
    output logic       LOCK_n,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE1,
        S_GAP,
        S_PULSE2,
        S_VALID
    } state_t;

    // Phase counter is loaded with length-1 so the phase ends on the edge it reads zero.
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [1:0] qual_q, qual_d;
    logic [3:0] cnt_q, cnt_d;
    logic       inta_q, inta_d;
    logic [7:0] vec_q, vec_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        cnt_d   = cnt_q;
        inta_d  = inta_q;
        vec_d   = vec_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (INT && IF_EN) begin
                    if (qual_q == 2'd1) begin
                        state_d = S_PULSE1;
                        qual_d  = '0;
                        cnt_d   = PULSE_LD;
                        inta_d  = 1'b0;
                    end else begin
                        qual_d = qual_q + 2'd1;
                    end
                end else begin
                    qual_d = '0;
                end
            end
            S_PULSE1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                    inta_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE2;
                    cnt_d   = PULSE_LD;
                    inta_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_PULSE2: begin
                if (cnt_q == '0) begin
                    state_d = S_VALID;
                    cnt_d   = '0;
                    inta_d  = 1'b1;
                    vec_d   = D;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_VALID: begin
                if (vec_ack) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    qual_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                qual_d  = '0;
                cnt_d   = '0;
                inta_d  = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            qual_q  <= '0;
            cnt_q   <= '0;
            inta_q  <= 1'b1;
            vec_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            cnt_q   <= cnt_d;
            inta_q  <= inta_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign INTA_n    = inta_q;
    assign vector    = vec_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;

`ifdef INTA_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = !((state_d == S_PULSE1) || (state_d == S_GAP) || (state_d == S_PULSE2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b1;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign LOCK_n = lock_q;
`endif

endmodule

// File: tb/tb_inta_master.sv
// Bench for inta_master: directed scenarios plus random traffic against an edge-counting model,
// on a default instance and a PULSE_CYC=1/GAP_CYC=3 instance.
module tb_inta_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       INT;
    logic       IF_EN;
    logic [7:0] D;
    logic       vec_ack;

    logic [1:0] inta_o, valid_o, busy_o, lock_o;
    logic [7:0] vec0, vec1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inta_master dut0 (
        .clk(clk), .reset(reset), .INT(INT), .IF_EN(IF_EN), .D(D), .vec_ack(vec_ack),
        .INTA_n(inta_o[0]), .vector(vec0), .vec_valid(valid_o[0]),
`ifdef INTA_LOCK_EN
        .LOCK_n(lock_o[0]),
`endif
        .busy(busy_o[0])
    );

    inta_master #(.PULSE_CYC(1), .GAP_CYC(3)) dut1 (
        .clk(clk), .reset(reset), .INT(INT), .IF_EN(IF_EN), .D(D), .vec_ack(vec_ack),
        .INTA_n(inta_o[1]), .vector(vec1), .vec_valid(valid_o[1]),
`ifdef INTA_LOCK_EN
        .LOCK_n(lock_o[1]),
`endif
        .busy(busy_o[1])
    );

`ifndef INTA_LOCK_EN
    assign lock_o = 2'b11;
`endif

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] got=%h want=%h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vec_of(input int i);
        return (i == 0) ? vec0 : vec1;
    endfunction

    // Model: a sequence is described only by the edge it started on; pulse/gap windows
    // follow from the elapsed edge count.
    int         P [2] = '{2, 1};
    int         G [2] = '{2, 3};
    int         edge_n = 0;
    int         m_mode [2];   // 0 idle, 1 acknowledging, 2 vector held
    int         m_qual [2];
    int         m_start[2];
    logic [7:0] m_vec  [2];
    bit         m_valid[2];

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mode[i] = 0; m_qual[i] = 0; m_vec[i] = 8'h00; m_valid[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (INT && IF_EN) begin
                    m_qual[i]++;
                    if (m_qual[i] == 2) begin
                        m_mode[i] = 1; m_start[i] = edge_n; m_qual[i] = 0;
                    end
                end else begin
                    m_qual[i] = 0;
                end
            end else if (m_mode[i] == 1) begin
                if (edge_n - m_start[i] == 2 * P[i] + G[i]) begin
                    m_mode[i] = 2; m_vec[i] = D; m_valid[i] = 1;
                end
            end else if (vec_ack) begin
                m_mode[i] = 0; m_valid[i] = 0; m_qual[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            int  k;
            logic exp_inta;
            k = edge_n - m_start[i];
            exp_inta = !((m_mode[i] == 1) && ((k < P[i]) || (k >= P[i] + G[i])));
            chk("INTA_n", i, {7'd0, inta_o[i]}, {7'd0, exp_inta});
            chk("vec_valid", i, {7'd0, valid_o[i]}, {7'd0, m_valid[i]});
            chk("vector", i, vec_of(i), m_vec[i]);
            chk("busy", i, {7'd0, busy_o[i]}, {7'd0, m_mode[i] != 0});
`ifdef INTA_LOCK_EN
            chk("LOCK_n", i, {7'd0, lock_o[i]}, {7'd0, m_mode[i] != 1});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp0 [8];
        logic [7:0] exp1 [8];
        int lock_low;
        reset = 1'b1; INT = 1'b0; IF_EN = 1'b0; D = 8'h00; vec_ack = 1'b0;
        repeat (3) step();
        chk("rst_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
        chk("rst_vector", 0, vec0, 8'h00);
        chk("rst_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        reset = 1'b0;
        step();

        // Basic sequence; INT stays high through VALID and must re-qualify afterwards.
        exp0 = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
        exp1 = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1};
        lock_low = 0;
        INT = 1'b1; IF_EN = 1'b1; D = 8'h4A;
        for (int e = 0; e < 8; e++) begin
            step();
            chk("seq_INTA_n", 0, {7'd0, inta_o[0]}, exp0[e]);
            chk("seq_INTA_n", 1, {7'd0, inta_o[1]}, exp1[e]);
            if (lock_o[1] == 1'b0) lock_low++;
        end
        chk("seq_vector", 0, vec0, 8'h4A);
        chk("seq_vector", 1, vec1, 8'h4A);
        chk("seq_valid", 0, {7'd0, valid_o[0]}, 8'd1);
`ifdef INTA_LOCK_EN
        chk("lock_low_cycles", 1, 8'(lock_low), 8'd5);
`endif
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        chk("ack_valid", 0, {7'd0, valid_o[0]}, 8'd0);
        chk("ack_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        step();
        chk("requal_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
        step();
        chk("requal_INTA_n", 0, {7'd0, inta_o[0]}, 8'd0);
        INT = 1'b0;
        repeat (12) step();
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        step();

        // One-edge INT glitch must not start a sequence.
        INT = 1'b1;
        step();
        INT = 1'b0;
        repeat (6) begin
            step();
            chk("glitch_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
            chk("glitch_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        end

        // INT held while interrupts are disabled, then enabled.
        IF_EN = 1'b0; INT = 1'b1;
        repeat (10) begin
            step();
            chk("masked_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        end
        IF_EN = 1'b1;
        step();
        chk("enable_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
        step();
        chk("enable_INTA_n", 0, {7'd0, inta_o[0]}, 8'd0);
        INT = 1'b0;
        repeat (10) step();
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        step();

        // INT withdrawn during the gap: sequence still completes.
        INT = 1'b1; D = 8'h11;
        repeat (4) step();
        INT = 1'b0; D = 8'h0F;
        step();
        step();
        chk("drop_second_pulse", 0, {7'd0, inta_o[0]}, 8'd0);
        step();
        step();
        chk("drop_vector", 0, vec0, 8'h0F);
        chk("drop_valid", 0, {7'd0, valid_o[0]}, 8'd1);
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        chk("drop_ack_valid", 0, {7'd0, valid_o[0]}, 8'd0);
        chk("drop_ack_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        step();

        // Asynchronous reset in the middle of the second pulse.
        INT = 1'b1; D = 8'hA5;
        repeat (6) step();
        chk("pre_rst_INTA_n", 0, {7'd0, inta_o[0]}, 8'd0);
        #1 reset = 1'b1;
        #1;
        chk("async_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
        chk("async_valid", 0, {7'd0, valid_o[0]}, 8'd0);
        chk("async_vector", 0, vec0, 8'h00);
        chk("async_busy", 0, {7'd0, busy_o[0]}, 8'd0);
        INT = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (5) begin
            step();
            chk("post_rst_busy", 0, {7'd0, busy_o[0]}, 8'd0);
            chk("post_rst_INTA_n", 0, {7'd0, inta_o[0]}, 8'd1);
        end

        // Random traffic, checked every edge by the model.
        for (int n = 0; n < 700; n++) begin
            INT     = ($urandom_range(0, 3) != 0);
            IF_EN   = ($urandom_range(0, 7) != 0);
            D       = 8'($urandom);
            vec_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
